// File: rtl/lm32_dp_ram_be.sv
// ----------------------------------------------------------------------------
// lm32_dp_ram_be
//
// Simple dual-port (one write port, one read port) RAM with per-byte write
// enables, write-first read-during-write behaviour, an optional output
// pipeline stage and an optional zero-fill sequence after reset.
//
// Parameters
//   data_width     : data port width in bits (multiple of 8)
//   addr_width     : address width; depth is 2**addr_width words
//   output_reg     : 1 adds a second read pipeline stage (latency 2 instead of 1)
//   clear_on_reset : 1 walks the whole array writing zero after reset
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   rst_i    : asynchronous active-high reset
//   we_i     : write enable
//   sel_i    : byte-lane write enables, bit k covers wdata_i[8k+7:8k]
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable
//   raddr_i  : read address
//   rdata_o  : read data
//   rvalid_o : one-cycle pulse when rdata_o carries a newly completed read
//   ready_o  : high once the memory accepts reads and writes
// ----------------------------------------------------------------------------
module lm32_dp_ram_be #(
    parameter int unsigned data_width     = 32,
    parameter int unsigned addr_width     = 5,
    parameter int unsigned output_reg     = 0,
    parameter int unsigned clear_on_reset = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [data_width/8-1:0] sel_i,
    input  logic [addr_width-1:0]   waddr_i,
    input  logic [data_width-1:0]   wdata_i,
    input  logic                    re_i,
    input  logic [addr_width-1:0]   raddr_i,
    output logic [data_width-1:0]   rdata_o,
    output logic                    rvalid_o,
    output logic                    ready_o
);

    localparam int unsigned NumLanes = data_width / 8;
    localparam int unsigned Depth    = 2 ** addr_width;

    localparam logic [addr_width-1:0] LastAddr = {addr_width{1'b1}};

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    localparam state_e ResetState = (clear_on_reset != 0) ? StClear : StReady;

    // ------------------------------------------------------------------------
    // Controller: CLEAR walks every address once, then READY forever.
    // ------------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [addr_width-1:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LastAddr) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = ResetState;
            end
        endcase
    end

    logic ready;
    logic clr_we;
    logic wr_en;
    logic rd_en;

    assign ready = (state_q == StReady);

    // Memory has no reset of its own, so every write is blocked while rst_i
    // is high; otherwise a READY-after-reset configuration could be written
    // by a stray we_i during reset.
    assign clr_we = (state_q == StClear) && !rst_i;
    assign wr_en  = ready && we_i && !rst_i;
    assign rd_en  = ready && re_i;

    // ------------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------------
    logic [data_width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NumLanes; k++) begin
                if (sel_i[k]) begin
                    mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path: write-first bypass on an address collision, per byte lane.
    // Unselected lanes of a colliding write return the old contents.
    // ------------------------------------------------------------------------
    logic [data_width-1:0] rd_word;

    always_comb begin
        rd_word = mem_q[raddr_i];
        if (wr_en && (waddr_i == raddr_i)) begin
            for (int k = 0; k < NumLanes; k++) begin
                if (sel_i[k]) begin
                    rd_word[8*k +: 8] = wdata_i[8*k +: 8];
                end
            end
        end
    end

    logic [data_width-1:0] rdata1_q;
    logic                  rvalid1_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ResetState;
            clr_cnt_q <= '0;
            rdata1_q  <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            // Holding on re_i=0 keeps rdata_o stable against later writes.
            if (rd_en) begin
                rdata1_q <= rd_word;
            end
            rvalid1_q <= rd_en;
        end
    end

    // ------------------------------------------------------------------------
    // Optional output stage
    // ------------------------------------------------------------------------
    if (output_reg != 0) begin : g_out_reg
        logic [data_width-1:0] rdata2_q;
        logic                  rvalid2_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rdata2_q  <= '0;
                rvalid2_q <= 1'b0;
            end else begin
                rdata2_q  <= rdata1_q;
                rvalid2_q <= rvalid1_q;
            end
        end

        assign rdata_o  = rdata2_q;
        assign rvalid_o = rvalid2_q;
    end else begin : g_no_out_reg
        assign rdata_o  = rdata1_q;
        assign rvalid_o = rvalid1_q;
    end

    assign ready_o = ready;

endmodule

// File: doc/lm32_dp_ram_be.md
LM32_DP_RAM_BE -- requirements
Module: lm32_dp_ram_be

Interface
REQ-001 The block SHALL have parameter data_width, default 32, giving the data port width; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter addr_width, default 5, giving the address width; depth SHALL be 2^addr_width words.
REQ-003 The block SHALL have parameter output_reg, default 0; a value of 1 SHALL add one output pipeline stage.
REQ-004 The block SHALL have parameter clear_on_reset, default 1; a value of 1 SHALL zero-fill memory after reset.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port we_i, input, 1 bit: write enable.
REQ-008 The block SHALL have port sel_i, input, data_width/8 bits: byte-lane write enables, where bit k covers wdata_i[8k+7:8k].
REQ-009 The block SHALL have port waddr_i, input, addr_width bits: write address.
REQ-010 The block SHALL have port wdata_i, input, data_width bits: write data.
REQ-011 The block SHALL have port re_i, input, 1 bit: read enable.
REQ-012 The block SHALL have port raddr_i, input, addr_width bits: read address.
REQ-013 The block SHALL have port rdata_o, output, data_width bits: read data.
REQ-014 The block SHALL have port rvalid_o, output, 1 bit: one-cycle pulse marking the cycle in which rdata_o carries a newly completed read.
REQ-015 The block SHALL have port ready_o, output, 1 bit: high when the memory accepts reads and writes.

Function
REQ-016 The controller SHALL have two states, CLEAR and READY, and ready_o SHALL be 1 only in READY.
REQ-017 On reset the state SHALL be CLEAR with clear counter 0 if clear_on_reset=1, and READY otherwise.
REQ-018 In CLEAR, each cycle SHALL write all-zero to mem[counter] and increment the counter.
REQ-019 In CLEAR, after the write to address 2^addr_width-1 the state SHALL become READY on the next edge, so ready_o rises exactly 2^addr_width cycles after rst_i deasserts.
REQ-020 In CLEAR, we_i and re_i SHALL be ignored: no user write, no read register update, and rvalid_o=0.
REQ-021 In READY with we_i=1, each lane k with sel_i[k]=1 SHALL be written to mem[waddr_i] at the edge, and lanes with sel_i[k]=0 SHALL be unchanged.
REQ-022 A write with we_i=1 and sel_i all-zero SHALL leave memory unchanged.
REQ-023 In READY with re_i=1, the stage-1 data register SHALL load mem[raddr_i] at the edge.
REQ-024 Read-during-write collision: when re_i=1, we_i=1 and raddr_i==waddr_i in the same cycle, each lane with sel_i[k]=1 SHALL return the wdata_i lane (write-first), and other lanes SHALL return the old memory contents.
REQ-025 With re_i=0, the stage-1 register SHALL hold its value, and rdata_o SHALL NOT change due to later writes to the previously read address.
REQ-026 With output_reg=0, rdata_o SHALL equal the stage-1 register: read latency 1 cycle.
REQ-027 With output_reg=1, a stage-2 register SHALL load the stage-1 register every cycle and drive rdata_o: read latency 2 cycles.
REQ-028 rvalid_o SHALL be re_i delayed by the read latency, and SHALL count only reads accepted in READY.
REQ-029 Back-to-back reads SHALL be accepted every cycle, giving one result per cycle.
REQ-030 Simultaneous reads and writes to different addresses SHALL be fully independent.

Reset
REQ-031 rst_i=1 SHALL asynchronously force: the state to its reset value, clear counter=0, stage-1 and stage-2 registers=0, the rvalid pipeline=0, rdata_o=0, rvalid_o=0, and ready_o=0 if clear_on_reset=1, else 1.
REQ-032 Memory contents SHALL NOT be reset asynchronously; zeroing SHALL occur only through CLEAR.
REQ-033 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-034 Reset asserted mid-read SHALL drop in-flight rvalid pulses.

Verification
REQ-035 Bench SHALL cover: addr_width=5, clear_on_reset=1, reset release -> ready_o=0 for 32 cycles then 1, and reads of all addresses return 0.
REQ-036 Bench SHALL cover: write 0xAABBCCDD to addr 3 with sel=1111, then sel=0010 with data 0x00001100 -> read of addr 3 returns 0xAABB11DD.
REQ-037 Bench SHALL cover: mem[7]=0x11223344, then in the same cycle write 0xFFFFFFFF with sel=0101 and read addr 7 -> rdata_o=0x11FF33FF one cycle later.
REQ-038 Bench SHALL cover: output_reg=1, reads of addrs 1,2,3 on consecutive cycles -> rvalid_o high on cycles 2,3,4 with matching data, and rvalid_o=0 otherwise.
REQ-039 Bench SHALL cover: read addr 4 (0x5), then re_i=0 while writing 0x9 to addr 4 -> rdata_o stays 0x5.
REQ-040 Bench SHALL cover: rst_i pulsed at clear counter 10 -> ready_o rises 32 cycles after the second release.
